bullet_controller: RTL and testbench
====================================

# bullet_controller

Per-player projectile engine feeding the VGA drawing engine's bullet inputs (BulletX/BulletY/bullet_on). It latches a fire request from the owning tank and spawns one bullet at the tank centre. It advances the bullet once per video frame along one of four directions and retires it on screen edge, barrier or opponent contact. A one-cycle hit pulse goes to the score logic. Two instances are built, one per player.

## Interface
- BULLET_STEP, 4: pixels moved per frame tick
- BULLET_SIZE, 2: bullet radius used for collision
- COOLDOWN_FRAMES, 30: frame ticks after retirement before the next fire is accepted
- Clk  in  1  system clock (single clock domain)
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame strobe (vsync-derived level); rising edge = one tick
- fire  in  1  fire button level; rising edge = fire request
- dir  in  2  tank facing: 00 up, 01 right, 10 down, 11 left
- TankX, TankY  in  10  owning tank centre
- OppX, OppY  in  10  opponent tank centre
- Tank_size  in  10  tank half-size (square)
- BarrierX, BarrierY  in  10  barrier centre
- Barrier_Length_Halved, Barrier_Height_Halved  in  10  barrier half-extents
- BulletX, BulletY  out  10  bullet centre
- bullet_on  out  1  bullet visible; the top level zero-extends it to the drawing engine's port width
- hit  out  1  one-cycle pulse: bullet struck the opponent

## Operation
- Edge detect: fire_q and frame_q are registered copies. fire_edge = fire & ~fire_q. tick = frame_clk & ~frame_q.
- States: IDLE, ACTIVE, COOLDOWN.
- IDLE:
  - bullet_on=0.
  - On fire_edge: load BulletX/Y = TankX/Y, latch dir into bdir, go to ACTIVE.
  - A tick in the same cycle causes no movement.
- ACTIVE, on tick: compute next position (nx, ny) = current position moved BULLET_STEP along bdir, then evaluate in priority order:
  1. Edge: up with BulletY < STEP; left with BulletX < STEP; down with BulletY+STEP > 479; right with BulletX+STEP > 639. Action: retire, no hit.
  2. Opponent: nx+BULLET_SIZE+Tank_size >= OppX, nx <= OppX+Tank_size+BULLET_SIZE, and the same test on Y. Action: retire, hit=1.
  3. Barrier: the same form using the barrier half-extents. Action: retire, no hit.
  4. None of the above: BulletX/Y <= nx/ny.
- Retire: go to COOLDOWN, clear bullet_on, hold BulletX/Y at the last drawn value, clear the cooldown counter.
- Opponent beats barrier when both match. Edge beats both.
- All comparisons use 11-bit unsigned additions; no subtraction, so there is no underflow.
- ACTIVE without a tick: hold.
- COOLDOWN:
  - Counter increments on each tick.
  - When the counter reaches COOLDOWN_FRAMES-1 on a tick, go to IDLE.
  - If COOLDOWN_FRAMES=0, go to IDLE on the first tick.
- fire_edge in ACTIVE or COOLDOWN is discarded, not queued.
- dir and TankX/Y changes after spawn do not affect the bullet.
- Opponent and barrier inputs are sampled live on each tick.

## Timing
- Reset (async, any state, including mid-flight):
  - State=IDLE, BulletX=0, BulletY=0, bullet_on=0, hit=0.
  - Counter=0, fire_q=0, frame_q=0.
- Spawn: fire_edge seen at clock edge N → bullet_on=1, BulletX/Y valid after edge N.
- Move: tick seen at edge N → new position visible after edge N; exactly one move per frame_clk rising edge.
- Retire: hit and the bullet_on 1→0 transition occur after the same edge; hit is high for exactly one cycle.
- If fire is held high through the cooldown, no new bullet spawns; a fresh rising edge is required.
- Minimum bullet period: 1 spawn + flight + COOLDOWN_FRAMES ticks.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset/spawn:
  - Stimulus: Reset_n low mid-ACTIVE, then release; TankX/Y=(320,240), dir=01, one fire edge.
  - Required: all outputs 0 during reset; bullet_on=1 and BulletX/Y=(320,240) one cycle after the edge.
  - Stimulus: 10 ticks.
  - Required: BulletX=360.
- Right edge:
  - Stimulus: dir=01, spawn at X=630, tick.
  - Required: 634.
  - Stimulus: next tick.
  - Required: 638 (638 ≤ 639).
  - Stimulus: next tick.
  - Required: 642 > 639, so retire, bullet_on=0, hit=0, BulletX holds 638.
- Opponent hit:
  - Stimulus: dir=10, spawn at (100,100); Opp=(100,130), Tank_size=8.
  - Required: retire with one-cycle hit=1 on the tick where ny reaches 120 (120+2+8 ≥ 130).
- Barrier:
  - Stimulus: dir=11, spawn at (300,50); Barrier=(250,50), half-length 20.
  - Required: retire without hit when nx=272 (≤ 250+20+2).
  - Stimulus: opponent placed inside the barrier span.
  - Required: hit=1 (opponent has priority).
- Cooldown/fire filtering:
  - Stimulus: COOLDOWN_FRAMES=3; fire edges during ACTIVE and cooldown ticks 1–2, fire held high.
  - Required: no spawn.
  - Stimulus: after 3 ticks, fire still held.
  - Required: no spawn.
  - Stimulus: release fire, then re-press.
  - Required: spawn.
- Same-cycle fire and tick in IDLE:
  - Required: spawn at the tank centre, no step.
  - Stimulus: dir changed after spawn.
  - Required: trajectory unchanged.

Source files
------------

// File: rtl/bullet_controller.sv
// Per-player projectile engine: spawns one bullet at the tank centre, steps it once per frame,
// and retires it on screen edge, opponent contact (with a one-cycle hit pulse) or barrier contact.
module bullet_controller #(
    parameter int BULLET_STEP     = 4,
    parameter int BULLET_SIZE     = 2,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [1:0] dir,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] OppX,
    input  logic [9:0] OppY,
    input  logic [9:0] Tank_size,
    input  logic [9:0] BarrierX,
    input  logic [9:0] BarrierY,
    input  logic [9:0] Barrier_Length_Halved,
    input  logic [9:0] Barrier_Height_Halved,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic       bullet_on,
    output logic       hit
);

    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

    localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES);
    localparam logic [CW-1:0] CD_LAST =
        CW'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);
    localparam logic [9:0]  STEP10 = 10'(BULLET_STEP);
    localparam logic [10:0] STEP   = 11'(BULLET_STEP);
    localparam logic [10:0] SIZE   = 11'(BULLET_SIZE);
    localparam logic [10:0] MAX_X  = 11'd639;
    localparam logic [10:0] MAX_Y  = 11'd479;

    state_t        state, state_n;
    logic          fire_q, frame_q;
    logic [1:0]    bdir, bdir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0]    x_n, y_n;
    logic          on_n, hit_n;

    logic          fire_edge, tick;
    logic [9:0]    nx, ny;
    logic [10:0]   bx, by, nxe, nye;
    logic [10:0]   ox, oy, ts, brx, bry, bl, bh;
    logic          at_edge, opp_hit, bar_hit, cd_done;

    assign fire_edge = fire & ~fire_q;
    assign tick      = frame_clk & ~frame_q;

    assign bx  = {1'b0, BulletX};
    assign by  = {1'b0, BulletY};
    assign nxe = {1'b0, nx};
    assign nye = {1'b0, ny};
    assign ox  = {1'b0, OppX};
    assign oy  = {1'b0, OppY};
    assign ts  = {1'b0, Tank_size};
    assign brx = {1'b0, BarrierX};
    assign bry = {1'b0, BarrierY};
    assign bl  = {1'b0, Barrier_Length_Halved};
    assign bh  = {1'b0, Barrier_Height_Halved};

    always_comb begin
        nx      = BulletX;
        ny      = BulletY;
        at_edge = 1'b0;
        unique case (bdir)
            2'd0: begin
                ny      = BulletY - STEP10;
                at_edge = by < STEP;
            end
            2'd1: begin
                nx      = BulletX + STEP10;
                at_edge = (bx + STEP) > MAX_X;
            end
            2'd2: begin
                ny      = BulletY + STEP10;
                at_edge = (by + STEP) > MAX_Y;
            end
            2'd3: begin
                nx      = BulletX - STEP10;
                at_edge = bx < STEP;
            end
        endcase
    end

    // Overlap tests are written add-only so nothing can underflow
    assign opp_hit = (nxe + SIZE + ts >= ox) && (nxe <= ox + ts + SIZE)
                  && (nye + SIZE + ts >= oy) && (nye <= oy + ts + SIZE);
    assign bar_hit = (nxe + SIZE + bl >= brx) && (nxe <= brx + bl + SIZE)
                  && (nye + SIZE + bh >= bry) && (nye <= bry + bh + SIZE);

    assign cd_done = (COOLDOWN_FRAMES == 0) || (cnt == CD_LAST);

    always_comb begin
        state_n = state;
        x_n     = BulletX;
        y_n     = BulletY;
        bdir_n  = bdir;
        cnt_n   = cnt;
        on_n    = 1'b0;
        hit_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fire_edge) begin
                    x_n     = TankX;
                    y_n     = TankY;
                    bdir_n  = dir;
                    on_n    = 1'b1;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                on_n = 1'b1;
                if (tick) begin
                    if (at_edge || opp_hit || bar_hit) begin
                        state_n = COOLDOWN;
                        on_n    = 1'b0;
                        cnt_n   = '0;
                        hit_n   = ~at_edge & opp_hit;
                    end else begin
                        x_n = nx;
                        y_n = ny;
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (cd_done) state_n = IDLE;
                    else cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            fire_q    <= 1'b0;
            frame_q   <= 1'b0;
            bdir      <= 2'd0;
            cnt       <= '0;
            BulletX   <= 10'd0;
            BulletY   <= 10'd0;
            bullet_on <= 1'b0;
            hit       <= 1'b0;
        end else begin
            state     <= state_n;
            fire_q    <= fire;
            frame_q   <= frame_clk;
            bdir      <= bdir_n;
            cnt       <= cnt_n;
            BulletX   <= x_n;
            BulletY   <= y_n;
            bullet_on <= on_n;
            hit       <= hit_n;
        end
    end

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: directed scenarios plus random stimulus,
// all checked against an integer-arithmetic flight model.
module tb_bullet_controller;

    localparam int CF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [9:0] tank_x = '0, tank_y = '0;
    logic [9:0] opp_x = 10'd1000, opp_y = 10'd1000;
    logic [9:0] tank_size = 10'd8;
    logic [9:0] bar_x = 10'd1000, bar_y = 10'd1000;
    logic [9:0] bar_lh = 10'd5, bar_hh = 10'd5;
    logic [9:0] bullet_x, bullet_y;
    logic       bullet_on, hit;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_flying, m_hit, m_fire_q, m_frame_q, saw_hit;
    int m_cool, mx, my, mdir;

    bullet_controller #(.COOLDOWN_FRAMES(CF)) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .frame_clk(frame_clk),
        .fire(fire),
        .dir(dir),
        .TankX(tank_x),
        .TankY(tank_y),
        .OppX(opp_x),
        .OppY(opp_y),
        .Tank_size(tank_size),
        .BarrierX(bar_x),
        .BarrierY(bar_y),
        .Barrier_Length_Halved(bar_lh),
        .Barrier_Height_Halved(bar_hh),
        .BulletX(bullet_x),
        .BulletY(bullet_y),
        .bullet_on(bullet_on),
        .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit near(int a, int b, int r);
        return (a - b <= r) && (b - a <= r);
    endfunction

    task automatic model_reset();
        m_flying = 0; m_hit = 0; m_fire_q = 0; m_frame_q = 0;
        m_cool = 0; mx = 0; my = 0; mdir = 0;
    endtask

    task automatic retire();
        m_flying = 0;
        m_cool = (CF == 0) ? 1 : CF;
    endtask

    task automatic model_step();
        bit fe = fire && !m_fire_q;
        bit tk = frame_clk && !m_frame_q;
        int nx, ny;
        m_hit = 0;
        if (m_flying) begin
            if (tk) begin
                nx = mx + ((mdir == 1) ? 4 : (mdir == 3) ? -4 : 0);
                ny = my + ((mdir == 2) ? 4 : (mdir == 0) ? -4 : 0);
                if (nx < 0 || nx > 639 || ny < 0 || ny > 479) retire();
                else if (near(nx, int'(opp_x), int'(tank_size) + 2) &&
                         near(ny, int'(opp_y), int'(tank_size) + 2)) begin
                    retire();
                    m_hit = 1;
                end else if (near(nx, int'(bar_x), int'(bar_lh) + 2) &&
                             near(ny, int'(bar_y), int'(bar_hh) + 2))
                    retire();
                else begin
                    mx = nx;
                    my = ny;
                end
            end
        end else if (m_cool > 0) begin
            if (tk) m_cool--;
        end else if (fe) begin
            mx = int'(tank_x); my = int'(tank_y); mdir = int'(dir);
            m_flying = 1;
        end
        m_fire_q  = fire;
        m_frame_q = frame_clk;
    endtask

    task automatic cyc();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        chk("on", bullet_on, m_flying);
        chk("hit", hit, m_hit);
        chk("x", bullet_x, mx);
        chk("y", bullet_y, my);
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        cyc();
        saw_hit = hit;
        frame_clk = 1'b0;
        cyc();
    endtask

    task automatic spawn(int x, int y, int d);
        tank_x = 10'(x); tank_y = 10'(y); dir = 2'(d);
        fire = 1'b1;
        cyc();
        chk("spawn_on", bullet_on, 1);
        chk("spawn_x", bullet_x, x);
        chk("spawn_y", bullet_y, y);
        fire = 1'b0;
        cyc();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (m_flying || m_cool > 0); i++) tick();
        chk("idle_bound", 32'(m_flying || m_cool > 0), 0);
    endtask

    task automatic clear_field();
        opp_x = 10'd1000; opp_y = 10'd1000; tank_size = 10'd8;
        bar_x = 10'd1000; bar_y = 10'd1000; bar_lh = 10'd5; bar_hh = 10'd5;
    endtask

    initial begin
        model_reset();
        repeat (3) cyc();
        chk("rst_on", bullet_on, 0);
        chk("rst_hit", hit, 0);
        chk("rst_x", bullet_x, 0);
        rst_n = 1'b1;

        spawn(320, 240, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_on", bullet_on, 0);
        chk("async_rst_x", bullet_x, 0);
        chk("async_rst_y", bullet_y, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        spawn(320, 240, 1);
        repeat (10) tick();
        chk("ten_ticks_x", bullet_x, 360);
        wait_idle();

        spawn(630, 240, 1);
        tick();
        chk("edge_634", bullet_x, 634);
        tick();
        chk("edge_638", bullet_x, 638);
        tick();
        chk("edge_off", bullet_on, 0);
        chk("edge_nohit", saw_hit, 0);
        chk("edge_hold", bullet_x, 638);
        wait_idle();

        opp_x = 10'd100; opp_y = 10'd130;
        spawn(100, 100, 2);
        repeat (4) tick();
        chk("opp_pre_on", bullet_on, 1);
        chk("opp_pre_y", bullet_y, 116);
        tick();
        chk("opp_hit", saw_hit, 1);
        chk("opp_off", bullet_on, 0);
        chk("opp_hold_y", bullet_y, 116);
        chk("hit_one_cycle", hit, 0);
        clear_field();
        wait_idle();

        bar_x = 10'd250; bar_y = 10'd50; bar_lh = 10'd20; bar_hh = 10'd10;
        spawn(300, 50, 3);
        repeat (6) tick();
        chk("bar_pre_x", bullet_x, 276);
        tick();
        chk("bar_off", bullet_on, 0);
        chk("bar_nohit", saw_hit, 0);
        chk("bar_hold_x", bullet_x, 276);
        wait_idle();

        opp_x = 10'd262; opp_y = 10'd50;
        spawn(300, 50, 3);
        repeat (7) tick();
        chk("prio_hit", saw_hit, 1);
        chk("prio_off", bullet_on, 0);
        clear_field();
        wait_idle();

        spawn(600, 240, 1);
        repeat (3) tick();
        fire = 1'b1; cyc();
        fire = 1'b0; cyc();
        chk("refire_active_x", bullet_x, 612);
        repeat (6) tick();
        chk("cd_pre_x", bullet_x, 636);
        tick();
        chk("cd_retired", bullet_on, 0);
        fire = 1'b1; cyc();
        tick();
        fire = 1'b0; cyc();
        fire = 1'b1; cyc();
        chk("cd_t1_on", bullet_on, 0);
        tick();
        chk("cd_t2_on", bullet_on, 0);
        tick();
        repeat (3) cyc();
        chk("held_fire_on", bullet_on, 0);
        fire = 1'b0; cyc();
        fire = 1'b1; cyc();
        chk("repress_on", bullet_on, 1);
        fire = 1'b0; cyc();
        wait_idle();

        tank_x = 10'd200; tank_y = 10'd200; dir = 2'd0;
        fire = 1'b1; frame_clk = 1'b1;
        cyc();
        chk("same_on", bullet_on, 1);
        chk("same_x", bullet_x, 200);
        chk("same_y", bullet_y, 200);
        fire = 1'b0; frame_clk = 1'b0;
        cyc();
        dir = 2'd1; tank_x = 10'd50;
        tick();
        chk("dir_lock_x", bullet_x, 200);
        chk("dir_lock_y", bullet_y, 196);
        tick();
        chk("dir_lock_y2", bullet_y, 192);
        wait_idle();

        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                tank_x    = 10'($urandom_range(0, 639));
                tank_y    = 10'($urandom_range(0, 479));
                tank_size = 10'($urandom_range(0, 31));
                opp_x     = 10'($urandom_range(0, 700));
                opp_y     = 10'($urandom_range(0, 700));
                bar_x     = 10'($urandom_range(0, 639));
                bar_y     = 10'($urandom_range(0, 479));
                bar_lh    = 10'($urandom_range(0, 63));
                bar_hh    = 10'($urandom_range(0, 63));
            end
            dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            rst_n = ($urandom_range(0, 699) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
